axis_pkt_rr_arbiter: RTL and testbench
======================================

Name: axis_pkt_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI-Stream sink among NUM source streams inside the integration top (test_tttop class designs).
- Once a source is granted, the arbiter stays locked to it until that source's tlast beat completes.
- Sits between per-channel stream producers and a single downstream consumer.
- Exposes the grant index and per-packet statistics for debug.

Parameters:
- NUM, 4, number of requesting source streams (2..16).
- DSIZE, 32, tdata width in bits.
- CNT_W, 16, width of the packet counter; it wraps.

Ports:
- global_sys_clk  input  1  system clock; every flop is on its rising edge.
- global_sys_rst  input  1  synchronous, active-high reset.
- s_tdata  input  NUM*DSIZE  source data; slice i is [i*DSIZE +: DSIZE].
- s_tvalid  input  NUM  per-source valid.
- s_tlast  input  NUM  per-source end of packet.
- s_tready  output  NUM  per-source ready.
- m_tdata  output  DSIZE  muxed data.
- m_tvalid  output  1  muxed valid.
- m_tlast  output  1  muxed last.
- m_tready  input  1  sink ready.
- grant_id  output  $clog2(NUM)  index of the locked source; holds its last value while IDLE.
- busy  output  1  high while in LOCK.
- pkt_cnt  output  CNT_W  number of packets completed, wrapping.

Behaviour:
- Reset values:
  - state = IDLE, grant_id = 0, busy = 0, pkt_cnt = 0.
  - Round-robin pointer rr_ptr = 0.
  - s_tready = 0, m_tvalid = 0.
- FSM: two states, IDLE and LOCK.
- IDLE:
  - s_tready = 0, m_tvalid = 0, busy = 0.
  - If any s_tvalid is high: pick the first index i with s_tvalid[i] = 1, scanning rr_ptr, rr_ptr+1, …, NUM-1, 0, … (modulo NUM).
  - Register grant_id = i and go to LOCK on the next edge.
  - Arbitration costs exactly 1 idle cycle per packet.
- LOCK:
  - Combinational pass-through of the granted source: m_tdata/m_tvalid/m_tlast = s_*[grant_id], s_tready[grant_id] = m_tready.
  - All other s_tready bits are 0.
  - busy = 1.
- End of packet: a beat with m_tvalid & m_tready & m_tlast.
  - Next edge: state goes to IDLE, rr_ptr = (grant_id+1) mod NUM, pkt_cnt increments by 1.
- Wrap-around: pkt_cnt goes from 2^CNT_W-1 to 0. The rr_ptr increment wraps modulo NUM, including non-power-of-2 NUM.
- Fairness: with all sources continuously valid, grants rotate 0,1,…,NUM-1,0.
- Single-beat packet (tlast on the first beat) is legal: LOCK lasts 1 cycle when m_tready is high.
- Backpressure: while m_tready = 0 in LOCK, hold state. Stability of m_tdata and m_tlast is inherited from the source.
- A source that drops tvalid mid-packet does not release the lock; only tlast releases it.
- Requests from other sources arriving during LOCK are ignored until the return to IDLE.
- Simultaneous requests in IDLE: resolved purely by rr_ptr order.
- Reset asserted mid-packet:
  - Next edge forces IDLE, rr_ptr = 0, pkt_cnt = 0.
  - The partial packet is abandoned; the arbiter does not regenerate it.
  - s_tready drops in the cycle after reset is sampled.
- Latency: first beat of a packet appears on m_* 1 cycle after the request is seen in IDLE. Data path latency in LOCK is 0 cycles (combinational).

Decomposition:
- Package axis_arb_pkg:
  - typedef of the state enum (IDLE, LOCK).
  - function rr_pick(valid, ptr) returning the index of the next valid bit at or after ptr (modulo NUM).
  - localparam helper for grant index width, clog2 with a minimum of 1.
- Sub-module rr_priority_sel:
  - Combinational rotate, priority-encode, un-rotate.
  - Inputs: NUM-bit request and pointer. Outputs: index and hit.
  - Reusable by other arbiters in the codebase.

Test Plan:
- Single source, 3-beat packet: NUM=4, source 2 sends 3 beats with tlast on the 3rd, m_tready = 1.
  - Required: grant_id = 2; m_* shows the 3 beats on cycles 1..3 after the request; pkt_cnt = 1; busy falls after the 3rd beat.
- Rotation: all 4 sources hold 2-beat packets continuously.
  - Required: grant order 0,1,2,3,0; each grant separated by 1 IDLE cycle; pkt_cnt = 5 after 5 packets.
- Backpressure: m_tready toggles 1,0,0,1 during a 4-beat packet from source 1.
  - Required: no beat lost or duplicated; s_tready[1] mirrors m_tready; other s_tready bits stay 0.
- Single-beat packets plus contention: sources 0 and 3 each send 1-beat packets with rr_ptr = 3.
  - Required: source 3 is served first, then source 0; each LOCK lasts 1 cycle.
- Reset mid-packet: assert global_sys_rst on beat 2 of 5 from source 2.
  - Required: state returns to IDLE, all outputs at reset values, pkt_cnt = 0.
  - Required: the next request from source 2 is granted, starting from rr_ptr = 0 order.
- Counter wrap: CNT_W = 4, send 17 packets.
  - Required: pkt_cnt reads 0 after the 16th packet and 1 after the 17th.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiters.
package axis_arb_pkg;

    typedef enum logic [0:0] {StIdle, StLock} arb_state_e;

    localparam int unsigned MaxNum = 16;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Behavioural form of the rotating priority pick: first set bit at or after ptr, modulo num.
    function automatic logic [3:0] rr_pick(input logic [MaxNum-1:0] valid,
                                           input logic [3:0]        ptr,
                                           input int unsigned       num);
        int unsigned j;
        logic        found;
        logic [3:0]  pick;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MaxNum; k++) begin
            if (k < num && !found) begin
                j = (32'(ptr) + k) % num;
                if (valid[j[3:0]]) begin
                    pick  = j[3:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_pkt_rr_arbiter_sel.sv
// Rotating priority selector: rotate requests by ptr, pick the lowest, rotate the index back.
module rr_priority_sel
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM = 4,
    parameter int unsigned IW  = idx_w(NUM)
) (
    input  logic [NUM-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [IW-1:0]  idx,
    output logic           hit
);

    logic [NUM-1:0] rot;
    logic [IW-1:0]  enc;
    logic [IW:0]    sum;

    always_comb begin
        rot = NUM'({req, req} >> ptr);
        enc = '0;
        hit = 1'b0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = IW'(i);
                hit = 1'b1;
            end
        end
        // Un-rotate without a divider; works for non-power-of-2 NUM.
        sum = {1'b0, enc} + {1'b0, ptr};
        idx = (sum >= (IW+1)'(NUM)) ? IW'(sum - (IW+1)'(NUM)) : sum[IW-1:0];
    end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream sink among NUM sources.
module axis_pkt_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM   = 4,
    parameter int unsigned DSIZE = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    global_sys_clk,
    input  logic                    global_sys_rst,
    input  logic [NUM*DSIZE-1:0]    s_tdata,
    input  logic [NUM-1:0]          s_tvalid,
    input  logic [NUM-1:0]          s_tlast,
    output logic [NUM-1:0]          s_tready,
    output logic [DSIZE-1:0]        m_tdata,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    input  logic                    m_tready,
    output logic [idx_w(NUM)-1:0]   grant_id,
    output logic                    busy,
    output logic [CNT_W-1:0]        pkt_cnt
);

    localparam int unsigned IW = idx_w(NUM);

    arb_state_e    state_q;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] nxt_ptr;
    logic          sel_hit;
    logic          eop;

    rr_priority_sel #(
        .NUM (NUM),
        .IW  (IW)
    ) u_sel (
        .req (s_tvalid),
        .ptr (rr_ptr_q),
        .idx (sel_idx),
        .hit (sel_hit)
    );

    // Zero-latency pass-through of the locked source.
    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
        if (state_q == StLock) begin
            m_tdata            = s_tdata[int'(grant_id) * DSIZE +: DSIZE];
            m_tvalid           = s_tvalid[grant_id];
            m_tlast            = s_tlast[grant_id];
            s_tready[grant_id] = m_tready;
        end
    end

    always_comb begin
        eop     = m_tvalid & m_tready & m_tlast;
        nxt_ptr = (grant_id == IW'(NUM - 1)) ? '0 : grant_id + 1'b1;
    end

    always_ff @(posedge global_sys_clk) begin
        if (global_sys_rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sel_hit) begin
                        grant_id <= sel_idx;
                        busy     <= 1'b1;
                        state_q  <= StLock;
                    end
                end
                StLock: begin
                    // Only tlast releases the lock; dropped tvalid just stalls.
                    if (eop) begin
                        rr_ptr_q <= nxt_ptr;
                        pkt_cnt  <= pkt_cnt + 1'b1;
                        busy     <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Self-checking bench: per-source beat queues, a packet-level arbitration model, scenario tasks.
module tb_axis_pkt_rr_arbiter;

    localparam int NUM   = 4;
    localparam int DSIZE = 32;
    localparam int CNT_W = 4;
    localparam int QD    = 64;

    logic                 clk = 1'b0;
    logic                 global_sys_rst;
    logic [NUM*DSIZE-1:0] s_tdata;
    logic [NUM-1:0]       s_tvalid;
    logic [NUM-1:0]       s_tlast;
    logic [NUM-1:0]       s_tready;
    logic [DSIZE-1:0]     m_tdata;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic                 m_tready;
    logic [1:0]           grant_id;
    logic                 busy;
    logic [CNT_W-1:0]     pkt_cnt;

    always #5 clk = ~clk;

    axis_pkt_rr_arbiter #(
        .NUM   (NUM),
        .DSIZE (DSIZE),
        .CNT_W (CNT_W)
    ) dut (
        .global_sys_clk (clk),
        .global_sys_rst (global_sys_rst),
        .s_tdata        (s_tdata),
        .s_tvalid       (s_tvalid),
        .s_tlast        (s_tlast),
        .s_tready       (s_tready),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tlast        (m_tlast),
        .m_tready       (m_tready),
        .grant_id       (grant_id),
        .busy           (busy),
        .pkt_cnt        (pkt_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Source-side beat queues (fixed arrays with head/tail indices).
    logic [DSIZE-1:0] bdata [NUM][QD];
    bit               blast [NUM][QD];
    int               head  [NUM];
    int               tail  [NUM];
    bit               gap_en = 1'b0;
    bit               rst    = 1'b0;

    // Packet-level reference model.
    bit m_locked = 1'b0;
    int m_grant  = 0;
    int m_ptr    = 0;
    int m_cnt    = 0;

    int dut_log[$];
    bit prev_busy = 1'b0;
    int rx_cnt    = 0;

    task automatic add_pkt(input int src, input int len);
        if (head[src] == tail[src]) begin
            head[src] = 0;
            tail[src] = 0;
        end
        for (int b = 0; b < len; b++) begin
            bdata[src][tail[src]] = $urandom;
            blast[src][tail[src]] = (b == len - 1);
            tail[src]++;
        end
    endtask

    function automatic bit pending();
        bit p = m_locked;
        for (int i = 0; i < NUM; i++) if (head[i] < tail[i]) p = 1'b1;
        return p;
    endfunction

    // One clock cycle: drive at posedge+1, check at posedge+2, advance model across the edge.
    task automatic step(input bit rdy);
        logic [NUM-1:0]   v;
        logic [NUM-1:0]   exp_rdy;
        logic [DSIZE-1:0] emd;
        bit               emv;
        bit               eml;
        bit               avail;
        bit               found;
        int               k;
        for (int i = 0; i < NUM; i++) begin
            avail = head[i] < tail[i];
            v[i]  = avail && !(gap_en && $urandom_range(0, 3) == 0);
            s_tdata[i*DSIZE +: DSIZE] = avail ? bdata[i][head[i]] : '0;
            s_tlast[i] = avail ? blast[i][head[i]] : 1'b0;
        end
        s_tvalid       = v;
        m_tready       = rdy;
        global_sys_rst = rst;
        #1;
        emv     = m_locked && v[m_grant];
        eml     = m_locked && s_tlast[m_grant];
        emd     = emv ? bdata[m_grant][head[m_grant]] : '0;
        exp_rdy = '0;
        if (m_locked) exp_rdy[m_grant] = rdy;

        checks++;
        if (busy !== m_locked) begin
            errors++; $display("FAIL busy: got %0b want %0b at %0t", busy, m_locked, $time);
        end
        checks++;
        if (grant_id !== 2'(m_grant)) begin
            errors++; $display("FAIL grant_id: got %0d want %0d at %0t", grant_id, m_grant, $time);
        end
        checks++;
        if (pkt_cnt !== 4'(m_cnt)) begin
            errors++; $display("FAIL pkt_cnt: got %0d want %0d at %0t", pkt_cnt, m_cnt, $time);
        end
        checks++;
        if (s_tready !== exp_rdy) begin
            errors++; $display("FAIL s_tready: got %b want %b at %0t", s_tready, exp_rdy, $time);
        end
        checks++;
        if (m_tvalid !== emv) begin
            errors++; $display("FAIL m_tvalid: got %0b want %0b at %0t", m_tvalid, emv, $time);
        end
        if (emv) begin
            checks++;
            if (m_tdata !== emd || m_tlast !== eml) begin
                errors++;
                $display("FAIL beat: got %h/%0b want %h/%0b at %0t", m_tdata, m_tlast, emd, eml,
                         $time);
            end
        end

        if (busy && !prev_busy) dut_log.push_back(int'(grant_id));
        prev_busy = busy;
        if (m_tvalid && m_tready) rx_cnt++;

        if (rst) begin
            m_locked = 1'b0;
            m_grant  = 0;
            m_ptr    = 0;
            m_cnt    = 0;
            for (int i = 0; i < NUM; i++) head[i] = tail[i];
        end else if (m_locked) begin
            if (v[m_grant] && rdy) begin
                k = head[m_grant];
                head[m_grant]++;
                if (blast[m_grant][k]) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_grant + 1) % NUM;
                    m_cnt    = (m_cnt + 1) % (1 << CNT_W);
                end
            end
        end else begin
            found = 1'b0;
            for (int n = 0; n < NUM; n++) begin
                k = (m_ptr + n) % NUM;
                if (!found && v[k]) begin
                    m_grant  = k;
                    m_locked = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget, input bit rand_rdy);
        int n = 0;
        while (pending() && n < budget) begin
            step(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        checks++;
        if (pending()) begin
            errors++; $display("FAIL drain_timeout: still pending after %0d cycles", budget);
        end
        step(1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        global_sys_rst = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || pkt_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_regs: got busy=%0b grant=%0d cnt=%0d want 0/0/0", busy, grant_id,
                     pkt_cnt);
        end
        checks++;
        if (s_tready !== 4'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: got s_tready=%b m_tvalid=%0b want 0/0", s_tready, m_tvalid);
        end
        global_sys_rst = 1'b0;
    endtask

    task automatic test_single();
        int rx0 = rx_cnt;
        add_pkt(2, 3);
        drain(20, 1'b0);
        checks++;
        if (grant_id !== 2'd2 || pkt_cnt !== 4'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single: got grant=%0d cnt=%0d busy=%0b want 2/1/0", grant_id, pkt_cnt,
                     busy);
        end
        checks++;
        if (rx_cnt - rx0 != 3) begin
            errors++; $display("FAIL single_beats: got %0d want 3", rx_cnt - rx0);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        dut_log.delete();
        for (int p = 0; p < 2; p++) for (int s = 0; s < NUM; s++) add_pkt(s, 2);
        repeat (15) step(1'b1);
        checks++;
        if (pkt_cnt !== 4'd5) begin
            errors++; $display("FAIL rotation_cnt: got %0d want 5", pkt_cnt);
        end
        drain(60, 1'b0);
        checks++;
        if (dut_log.size() != 8) begin
            errors++; $display("FAIL rotation_grants: got %0d grants want 8", dut_log.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (dut_log[k] != k % NUM) begin
                    errors++;
                    $display("FAIL rotation_order[%0d]: got %0d want %0d", k, dut_log[k], k % NUM);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int pat[4] = '{1, 0, 0, 1};
        int rx0;
        int n = 0;
        do_reset();
        rx0 = rx_cnt;
        add_pkt(1, 4);
        step(1'b1);
        while (pending() && n < 30) begin
            step(1'(pat[n % 4]));
            n++;
        end
        step(1'b1);
        checks++;
        if (rx_cnt - rx0 != 4) begin
            errors++; $display("FAIL backpressure_beats: got %0d want 4", rx_cnt - rx0);
        end
        checks++;
        if (pkt_cnt !== 4'd1) begin
            errors++; $display("FAIL backpressure_cnt: got %0d want 1", pkt_cnt);
        end
    endtask

    task automatic test_single_beat_contention();
        add_pkt(2, 1);
        drain(10, 1'b0);
        dut_log.delete();
        add_pkt(0, 1);
        add_pkt(3, 1);
        drain(10, 1'b0);
        checks++;
        if (dut_log.size() != 2 || dut_log[0] != 3 || dut_log[1] != 0) begin
            errors++;
            $display("FAIL contention_order: got %0d grants first=%0d want 2 grants 3 then 0",
                     dut_log.size(), dut_log.size() > 0 ? dut_log[0] : -1);
        end
    endtask

    task automatic test_reset_mid_packet();
        add_pkt(2, 5);
        step(1'b1);
        step(1'b1);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || pkt_cnt !== 4'd0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL midreset_regs: got busy=%0b cnt=%0d grant=%0d want 0/0/0", busy,
                     pkt_cnt, grant_id);
        end
        checks++;
        if (s_tready !== 4'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outs: got s_tready=%b m_tvalid=%0b want 0/0", s_tready,
                     m_tvalid);
        end
        dut_log.delete();
        add_pkt(2, 1);
        add_pkt(0, 1);
        drain(20, 1'b0);
        checks++;
        if (dut_log.size() != 2 || dut_log[0] != 0 || dut_log[1] != 2) begin
            errors++;
            $display("FAIL midreset_order: got %0d grants first=%0d want 0 then 2",
                     dut_log.size(), dut_log.size() > 0 ? dut_log[0] : -1);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int p = 0; p < 16; p++) add_pkt($urandom_range(0, NUM - 1), 1);
        drain(200, 1'b0);
        checks++;
        if (pkt_cnt !== 4'd0) begin
            errors++; $display("FAIL wrap_16: got %0d want 0", pkt_cnt);
        end
        add_pkt($urandom_range(0, NUM - 1), 1);
        drain(20, 1'b0);
        checks++;
        if (pkt_cnt !== 4'd1) begin
            errors++; $display("FAIL wrap_17: got %0d want 1", pkt_cnt);
        end
    endtask

    task automatic test_random();
        int rx0 = rx_cnt;
        int beats = 0;
        int len;
        gap_en = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int s = 0; s < NUM; s++) begin
                len = $urandom_range(1, 4);
                beats += len;
                add_pkt(s, len);
            end
        end
        drain(2000, 1'b1);
        gap_en = 1'b0;
        checks++;
        if (rx_cnt - rx0 != beats) begin
            errors++; $display("FAIL random_beats: got %0d want %0d", rx_cnt - rx0, beats);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_single_beat_contention();
        test_reset_mid_packet();
        test_counter_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
